// File: rtl/sdr_init_fsm.sv
// SDRAM power-up init sequencer: NOP wait, PRECHARGE ALL, 2x AUTO REFRESH, LOAD MODE REGISTER.
// Optional SDR_INIT_FAST_SIM_EN shortens the power-up NOP wait to 16 cycles for simulation.
package sdr_parameters;
  localparam int d100US       = 5000;
  localparam int NUM_CLK_tRP  = 0;
  localparam int NUM_CLK_tRFC = 3;
  localparam int NUM_CLK_tMRD = 2;

  localparam int SDR_A_WIDTH  = 12;
  localparam int SDR_BA_WIDTH = 2;

  localparam logic       MR_Write_Burst_Mode = 1'b1;
  localparam logic [1:0] MR_Operation_Mode   = 2'b00;
  localparam logic [2:0] MR_CAS_Latency      = 3'b010;
  localparam logic       MR_Burst_Type       = 1'b0;
  localparam logic [2:0] MR_Burst_Length     = 3'b000;

  // {CSn, RASn, CASn, WEn}
  localparam logic [3:0] CMD_INHIBIT            = 4'b1111;
  localparam logic [3:0] CMD_NOP                = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE             = 4'b0011;
  localparam logic [3:0] CMD_READ               = 4'b0101;
  localparam logic [3:0] CMD_WRITE              = 4'b0100;
  localparam logic [3:0] CMD_BURST_TERMINATE    = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE          = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH       = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE_REGISTER = 4'b0000;

  localparam logic [3:0] i_NOP   = 4'd0;
  localparam logic [3:0] i_PRE   = 4'd1;
  localparam logic [3:0] i_tRP   = 4'd2;
  localparam logic [3:0] i_AR1   = 4'd3;
  localparam logic [3:0] i_tRFC1 = 4'd4;
  localparam logic [3:0] i_AR2   = 4'd5;
  localparam logic [3:0] i_tRFC2 = 4'd6;
  localparam logic [3:0] i_MRS   = 4'd7;
  localparam logic [3:0] i_tMRD  = 4'd8;
  localparam logic [3:0] i_ready = 4'd9;
endpackage

module sdr_init_fsm
  import sdr_parameters::*;
#(
  parameter int P_WAIT_PWRUP = d100US,
  parameter int P_CLK_TRP    = NUM_CLK_tRP,
  parameter int P_CLK_TRFC   = NUM_CLK_tRFC,
  parameter int P_CLK_TMRD   = NUM_CLK_tMRD,
  parameter logic [SDR_A_WIDTH-1:0] P_MODE_WORD = {2'b00, MR_Write_Burst_Mode, MR_Operation_Mode,
                                                   MR_CAS_Latency, MR_Burst_Type, MR_Burst_Length}
) (
  input  logic                    sys_CLK,
  input  logic                    sys_RESET,
  output logic                    sdr_CKE,
  output logic [3:0]              sdr_CMD,
  output logic [SDR_A_WIDTH-1:0]  sdr_A,
  output logic [SDR_BA_WIDTH-1:0] sdr_BA,
  output logic [3:0]              istate,
  output logic                    sys_INIT_DONE
);

  // wait-counter load value for a duration of c cycles (0 counts as 1)
  function automatic logic [12:0] m1(int c);
    return (c > 1) ? 13'(c - 1) : 13'd0;
  endfunction

`ifdef SDR_INIT_FAST_SIM_EN
  localparam logic [12:0] WAIT_M1 = m1(16);
`else
  localparam logic [12:0] WAIT_M1 = m1(P_WAIT_PWRUP);
`endif
  localparam logic [12:0] TRP_M1  = m1(P_CLK_TRP);
  localparam logic [12:0] TRFC_M1 = m1(P_CLK_TRFC);
  localparam logic [12:0] TMRD_M1 = m1(P_CLK_TMRD);

  logic [12:0]            cnt, cnt_n;
  logic                   boot, boot_n;   // next edge (re)loads the power-up wait
  logic [3:0]             nxt;
  logic [3:0]             cmd_d;
  logic [SDR_A_WIDTH-1:0] a_d;
  logic                   done_d;
  logic                   go;

  assign go     = (cnt == 13'd0);
  assign sdr_BA = '0;

  always_ff @(posedge sys_CLK or posedge sys_RESET) begin
    if (sys_RESET) begin
      istate        <= i_NOP;
      cnt           <= '0;
      boot          <= 1'b1;
      sdr_CKE       <= 1'b0;
      sdr_CMD       <= CMD_INHIBIT;
      sdr_A         <= '0;
      sys_INIT_DONE <= 1'b0;
    end else begin
      istate        <= nxt;
      cnt           <= cnt_n;
      boot          <= boot_n;
      sdr_CKE       <= 1'b1;
      sdr_CMD       <= cmd_d;
      sdr_A         <= a_d;
      sys_INIT_DONE <= done_d;
    end
  end

  always_comb begin
    nxt    = istate;
    boot_n = 1'b0;
    cnt_n  = go ? 13'd0 : cnt - 13'd1;
    if (boot) begin
      nxt   = i_NOP;
      cnt_n = WAIT_M1;
    end else begin
      case (istate)
        i_NOP:   if (go) begin nxt = i_PRE;   cnt_n = 13'd0;   end
        i_PRE:   if (go) begin nxt = i_tRP;   cnt_n = TRP_M1;  end
        i_tRP:   if (go) begin nxt = i_AR1;   cnt_n = 13'd0;   end
        i_AR1:   if (go) begin nxt = i_tRFC1; cnt_n = TRFC_M1; end
        i_tRFC1: if (go) begin nxt = i_AR2;   cnt_n = 13'd0;   end
        i_AR2:   if (go) begin nxt = i_tRFC2; cnt_n = TRFC_M1; end
        i_tRFC2: if (go) begin nxt = i_MRS;   cnt_n = 13'd0;   end
        i_MRS:   if (go) begin nxt = i_tMRD;  cnt_n = TMRD_M1; end
        i_tMRD:  if (go) begin nxt = i_ready; cnt_n = 13'd0;   end
        i_ready: cnt_n = 13'd0;
        default: begin
          nxt    = i_NOP;
          boot_n = 1'b1;
          cnt_n  = 13'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as istate.
  always_comb begin
    cmd_d  = CMD_NOP;
    a_d    = '0;
    done_d = 1'b0;
    case (nxt)
      i_PRE: begin
        cmd_d   = CMD_PRECHARGE;
        a_d[10] = 1'b1;
      end
      i_AR1, i_AR2: cmd_d = CMD_AUTO_REFRESH;
      i_MRS: begin
        cmd_d = CMD_LOAD_MODE_REGISTER;
        a_d   = P_MODE_WORD;
      end
      // Raised in the last tMRD cycle: the command FSM registers it and leaves
      // c_idle on the same edge this FSM reaches i_ready.
      i_tMRD:  done_d = (cnt_n == 13'd0);
      i_ready: done_d = 1'b1;
      default: ;
    endcase
    if (boot_n) cmd_d = CMD_INHIBIT;
  end

endmodule

// File: tb/tb_sdr_init_fsm.sv
// Bench for sdr_init_fsm: default and zero-timing instances against an interval-based sequence model,
// with randomized asynchronous resets and an illegal-state deposit.
module tb_sdr_init_fsm;
  localparam logic [3:0] NOP = 4'b0111, INH = 4'b1111, PRE = 4'b0010, AR = 4'b0001, LMR = 4'b0000;
`ifdef SDR_INIT_FAST_SIM_EN
  localparam int W = 16, W0 = 16;
`else
  localparam int W = 5000, W0 = 20;
`endif

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [11:0] a;
    logic [1:0]  ba;
    logic [3:0]  st;
    logic        done;
  } obs_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cke, done, cke0, done0;
  logic [3:0] cmd, st, cmd0, st0;
  logic [11:0] a, a0;
  logic [1:0] ba, ba0;
  obs_t o_dut, o_dut0;
  int n = 0, n0 = 0, total = 0, bad = 0, r;

  always #10 clk = ~clk;

  sdr_init_fsm dut (
    .sys_CLK(clk), .sys_RESET(rst), .sdr_CKE(cke), .sdr_CMD(cmd), .sdr_A(a),
    .sdr_BA(ba), .istate(st), .sys_INIT_DONE(done)
  );

  sdr_init_fsm #(.P_WAIT_PWRUP(20), .P_CLK_TRP(0), .P_CLK_TRFC(0), .P_CLK_TMRD(0)) dut0 (
    .sys_CLK(clk), .sys_RESET(rst), .sdr_CKE(cke0), .sdr_CMD(cmd0), .sdr_A(a0),
    .sdr_BA(ba0), .istate(st0), .sys_INIT_DONE(done0)
  );

  assign o_dut  = {cke, cmd, a, ba, st, done};
  assign o_dut0 = {cke0, cmd0, a0, ba0, st0, done0};

  // Expected outputs n edges after reset release, from cumulative state durations.
  function automatic obs_t model(int k, int w, int trp, int trfc, int tmrd);
    int dur[9];
    logic [3:0] cm[9];
    int start;
    obs_t o;
    dur = '{w, 1, (trp < 1) ? 1 : trp, 1, (trfc < 1) ? 1 : trfc, 1, (trfc < 1) ? 1 : trfc,
            1, (tmrd < 1) ? 1 : tmrd};
    cm  = '{NOP, PRE, NOP, AR, NOP, AR, NOP, LMR, NOP};
    o = '{cke: 1'b0, cmd: INH, a: 12'h000, ba: 2'b00, st: 4'd0, done: 1'b0};
    if (k <= 0) return o;
    o.cke = 1'b1;
    o.cmd = NOP;
    o.st  = 4'd9;
    start = 1;
    for (int i = 0; i < 9; i++) begin
      if (k >= start && k < start + dur[i]) begin
        o.st  = 4'(i);
        o.cmd = cm[i];
        if (i == 1) o.a = 12'h400;
        if (i == 7) o.a = 12'h220;
      end
      start += dur[i];
    end
    o.done = (k >= start - 1);
    return o;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s n=%0d n0=%0d got=%h exp=%h", tag, n, n0, got, exp);
    end
  endtask

  task automatic check_rst(string tag);
    check({tag, "_main"}, 32'(o_dut),  32'(model(0, W, 0, 3, 2)));
    check({tag, "_fast"}, 32'(o_dut0), 32'(model(0, W0, 0, 0, 0)));
  endtask

  task automatic tick(bit chk_main);
    @(posedge clk);
    #1;
    n++;
    n0++;
    if (chk_main) check("seq_main", 32'(o_dut), 32'(model(n, W, 0, 3, 2)));
    check("seq_fast", 32'(o_dut0), 32'(model(n0, W0, 0, 0, 0)));
  endtask

  // Reset asserted mid-cycle; outputs must collapse before the next edge.
  task automatic async_reset(int hold);
    #($urandom_range(2, 7));
    rst = 1'b1;
    #1;
    n  = 0;
    n0 = 0;
    check_rst("rst_async");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_rst("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_rst("rst_init");
    end
    rst = 1'b0;

    // full sequence, then 1000 cycles parked in i_ready
    repeat (W + 14 + 1000) tick(1'b1);

    // reset from i_ready, then reset again while in i_tRFC1
    async_reset(1);
    r = W + 4 + int'($urandom_range(0, 2));
    repeat (r) tick(1'b1);
    check("in_trfc1", 32'(st), 32'd4);
    async_reset(int'($urandom_range(1, 3)));
    repeat (W + 20) tick(1'b1);

    // resets at random points of the sequence
    for (int k = 0; k < 2; k++) begin
      r = int'($urandom_range(1, W + 14));
      repeat (r) tick(1'b1);
      async_reset(int'($urandom_range(0, 2)));
    end
    repeat (W + 20) tick(1'b1);

    // unused encoding deposited into istate
    @(negedge clk);
    force dut.istate = 4'd12;
    #2;
    release dut.istate;
    @(posedge clk);
    #1;
    n0++;
    check("seq_fast", 32'(o_dut0), 32'(model(n0, W0, 0, 0, 0)));
    check("illegal_state", 32'(st), 32'd0);
    check("illegal_cmd", 32'(cmd), 32'(INH));
    n = 0;
    repeat (W + 20) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
